// File: rtl/arb_mux_2to1_80bit_ctrl.sv
// Round-robin controller for an external 2:1 data mux plus a single-entry
// output register with a valid/ready handshake and per-source saturating
// transfer counters.
module arb_mux_2to1_80bit_ctrl #(
    parameter int unsigned WIDTH     = 80,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 In0Valid,
    input  logic                 In1Valid,
    output logic                 In0Ready,
    output logic                 In1Ready,
    output logic                 Select,
    input  logic [WIDTH-1:0]     MuxOut,
    output logic [WIDTH-1:0]     Out,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [CNT_WIDTH-1:0] Xfer0Count,
    output logic [CNT_WIDTH-1:0] Xfer1Count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last_grant;
    logic [WIDTH-1:0]     r_out;
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_cnt1;

    logic                 w_room;
    logic                 w_grant;
    logic                 w_accept;

    // Output-register state: fill on accept, drain when consumed without refill
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, handshake and next-state decode
    always_comb begin
        w_room      = 1'b0;
        w_grant     = r_last_grant;
        w_accept    = 1'b0;
        w_state_nxt = r_state;

        w_room = (r_state == ST_EMPTY) | OutReady;

        if (In0Valid && In1Valid) begin
            w_grant = ~r_last_grant;
        end else if (In1Valid) begin
            w_grant = 1'b1;
        end else if (In0Valid) begin
            w_grant = 1'b0;
        end else begin
            w_grant = r_last_grant;
        end

        // Reset gates acceptance so sources never see Ready while held in reset
        w_accept = (In0Valid | In1Valid) & w_room & ~Reset;

        if (w_accept) begin
            w_state_nxt = ST_FULL;
        end else if ((r_state == ST_FULL) && OutReady) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // Data capture and round-robin pointer, both only move on an accepted transfer
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_out        <= '0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_out        <= MuxOut;
            r_last_grant <= w_grant;
        end
    end

    // Per-source transfer counters, holding once all ones
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_accept) begin
            if (!w_grant && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end
            if (w_grant && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end
        end
    end

    assign Select     = w_grant;
    assign In0Ready   = w_accept & ~w_grant;
    assign In1Ready   = w_accept & w_grant;
    assign Out        = r_out;
    assign OutValid   = (r_state == ST_FULL);
    assign Xfer0Count = r_cnt0;
    assign Xfer1Count = r_cnt1;

endmodule

// File: tb/tb_arb_mux_2to1_80bit_ctrl.sv
// Bench for arb_mux_2to1_80bit_ctrl: directed vector table, hand-written
// saturation and mid-stream reset sequences, then randomized traffic against
// a rule-level reference model.
module tb_arb_mux_2to1_80bit_ctrl;

    localparam int unsigned WIDTH     = 80;
    localparam int unsigned CNT_WIDTH = 4;
    localparam int          CMAX      = 15;

    logic                 Clock = 1'b0;
    logic                 Reset = 1'b1;
    logic                 In0Valid = 1'b0;
    logic                 In1Valid = 1'b0;
    logic                 In0Ready;
    logic                 In1Ready;
    logic                 Select;
    logic [WIDTH-1:0]     MuxOut;
    logic [WIDTH-1:0]     Out;
    logic                 OutValid;
    logic                 OutReady = 1'b0;
    logic [CNT_WIDTH-1:0] Xfer0Count;
    logic [CNT_WIDTH-1:0] Xfer1Count;

    logic [WIDTH-1:0]     d0 = '0;
    logic [WIDTH-1:0]     d1 = '0;

    int tests  = 0;
    int failed = 0;

    // External mux
    assign MuxOut = Select ? d1 : d0;

    always #5 Clock = ~Clock;

    arb_mux_2to1_80bit_ctrl #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .In0Valid   (In0Valid),
        .In1Valid   (In1Valid),
        .In0Ready   (In0Ready),
        .In1Ready   (In1Ready),
        .Select     (Select),
        .MuxOut     (MuxOut),
        .Out        (Out),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .Xfer0Count (Xfer0Count),
        .Xfer1Count (Xfer1Count)
    );

    typedef struct {
        logic             v0;
        logic             v1;
        logic             ordy;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic             sel;
        logic             r0;
        logic             r1;
        logic             ov;
        logic [WIDTH-1:0] out;
        int               c0;
        int               c1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] pa(input int i);
        return 80'h0A0A_0000 + WIDTH'(i);
    endfunction

    function automatic logic [WIDTH-1:0] pb(input int i);
        return 80'h0B0B_0000 + WIDTH'(i);
    endfunction

    function automatic void add(input logic v0, input logic v1, input logic ordy,
                                input logic sel, input logic r0, input logic r1,
                                input logic ov, input logic [WIDTH-1:0] out,
                                input int c0, input int c1);
        vec_t v;
        int   k;
        k      = vecs.size();
        v.v0   = v0;
        v.v1   = v1;
        v.ordy = ordy;
        v.d0   = (k == 8) ? {10{8'hA5}} : pa(k);
        v.d1   = pb(k);
        v.sel  = sel;
        v.r0   = r0;
        v.r1   = r1;
        v.ov   = ov;
        v.out  = out;
        v.c0   = c0;
        v.c1   = c1;
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        Reset    = 1'b1;
        In0Valid = 1'b0;
        In1Valid = 1'b0;
        OutReady = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    // Reference model state
    logic             m_ov;
    logic [WIDTH-1:0] m_out;
    logic             m_last;
    int               m_c0;
    int               m_c1;

    initial begin
        logic g, room, acc;
        logic [WIDTH-1:0] a5;
        a5 = {10{8'hA5}};

        // v0 v1 rdy | sel r0 r1 | ov out c0 c1 (ov/out/counts after the edge)
        add(1, 1, 1, 0, 1, 0, 1, pa(0), 1, 0);
        add(1, 1, 1, 1, 0, 1, 1, pb(1), 1, 1);
        add(1, 1, 1, 0, 1, 0, 1, pa(2), 2, 1);
        add(1, 1, 1, 1, 0, 1, 1, pb(3), 2, 2);
        add(0, 1, 1, 1, 0, 1, 1, pb(4), 2, 3);
        add(0, 1, 1, 1, 0, 1, 1, pb(5), 2, 4);
        add(0, 1, 1, 1, 0, 1, 1, pb(6), 2, 5);
        add(1, 1, 1, 0, 1, 0, 1, pa(7), 3, 5);
        add(1, 0, 1, 0, 1, 0, 1, a5,    4, 5);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 1, 0, 0, 1, a5, 4, 5);
        add(1, 1, 1, 1, 0, 1, 1, pb(14), 4, 6);
        add(0, 1, 1, 1, 0, 1, 1, pb(15), 4, 7);
        add(0, 0, 1, 1, 0, 0, 0, pb(15), 4, 7);
        add(0, 0, 0, 1, 0, 0, 0, pb(15), 4, 7);
        add(1, 0, 0, 0, 1, 0, 1, pa(18), 5, 7);

        do_reset();
        chk("rst_out", Out, '0);
        chk("rst_ov", WIDTH'(OutValid), '0);
        chk("rst_c0", WIDTH'(Xfer0Count), '0);
        chk("rst_c1", WIDTH'(Xfer1Count), '0);
        chk("rst_sel_idle", WIDTH'(Select), WIDTH'(1));

        foreach (vecs[k]) begin
            In0Valid = vecs[k].v0;
            In1Valid = vecs[k].v1;
            OutReady = vecs[k].ordy;
            d0       = vecs[k].d0;
            d1       = vecs[k].d1;
            @(negedge Clock);
            chk($sformatf("v%0d_sel", k), WIDTH'(Select), WIDTH'(vecs[k].sel));
            chk($sformatf("v%0d_r0", k), WIDTH'(In0Ready), WIDTH'(vecs[k].r0));
            chk($sformatf("v%0d_r1", k), WIDTH'(In1Ready), WIDTH'(vecs[k].r1));
            @(posedge Clock);
            #1;
            chk($sformatf("v%0d_ov", k), WIDTH'(OutValid), WIDTH'(vecs[k].ov));
            chk($sformatf("v%0d_out", k), Out, vecs[k].out);
            chk($sformatf("v%0d_c0", k), WIDTH'(Xfer0Count), WIDTH'(vecs[k].c0));
            chk($sformatf("v%0d_c1", k), WIDTH'(Xfer1Count), WIDTH'(vecs[k].c1));
        end

        // Counter saturation: 17 source-0 transfers
        do_reset();
        for (int i = 0; i < 17; i++) begin
            In0Valid = 1'b1;
            In1Valid = 1'b0;
            OutReady = 1'b1;
            d0       = pa(100 + i);
            @(posedge Clock);
            #1;
            chk($sformatf("sat%0d_c0", i), WIDTH'(Xfer0Count), WIDTH'((i + 1 > CMAX) ? CMAX : i + 1));
        end
        chk("sat_c1", WIDTH'(Xfer1Count), '0);
        chk("sat_out", Out, pa(116));

        // Reset asserted between edges mid-stream
        In0Valid = 1'b1;
        In1Valid = 1'b1;
        OutReady = 1'b1;
        repeat (3) @(posedge Clock);
        #2;
        chk("mrst_pre_ov", WIDTH'(OutValid), WIDTH'(1));
        Reset = 1'b1;
        #1;
        chk("mrst_ov", WIDTH'(OutValid), '0);
        chk("mrst_c0", WIDTH'(Xfer0Count), '0);
        chk("mrst_c1", WIDTH'(Xfer1Count), '0);
        chk("mrst_r0", WIDTH'(In0Ready), '0);
        chk("mrst_r1", WIDTH'(In1Ready), '0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("mrst_tie_sel", WIDTH'(Select), '0);
        chk("mrst_tie_r0", WIDTH'(In0Ready), WIDTH'(1));

        // Randomized traffic against the reference model
        do_reset();
        m_ov   = 1'b0;
        m_out  = '0;
        m_last = 1'b1;
        m_c0   = 0;
        m_c1   = 0;
        for (int n = 0; n < 400; n++) begin
            In0Valid = ($urandom_range(0, 3) != 0);
            In1Valid = ($urandom_range(0, 2) != 0);
            OutReady = ($urandom_range(0, 3) != 0);
            d0       = {$urandom, $urandom, $urandom};
            d1       = {$urandom, $urandom, $urandom};

            room = !m_ov || OutReady;
            if (In0Valid && In1Valid) g = !m_last;
            else if (In0Valid || In1Valid) g = In1Valid;
            else g = m_last;
            acc = (In0Valid || In1Valid) && room;

            @(negedge Clock);
            chk($sformatf("rnd%0d_sel", n), WIDTH'(Select), WIDTH'(g));
            chk($sformatf("rnd%0d_r0", n), WIDTH'(In0Ready), WIDTH'(acc && !g));
            chk($sformatf("rnd%0d_r1", n), WIDTH'(In1Ready), WIDTH'(acc && g));
            chk($sformatf("rnd%0d_ov", n), WIDTH'(OutValid), WIDTH'(m_ov));
            chk($sformatf("rnd%0d_out", n), Out, m_out);
            chk($sformatf("rnd%0d_c0", n), WIDTH'(Xfer0Count), WIDTH'(m_c0));
            chk($sformatf("rnd%0d_c1", n), WIDTH'(Xfer1Count), WIDTH'(m_c1));
            @(posedge Clock);
            if (acc) begin
                m_out  = g ? d1 : d0;
                m_ov   = 1'b1;
                m_last = g;
                if (g) m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
                else   m_c0 = (m_c0 < CMAX) ? m_c0 + 1 : CMAX;
            end else if (m_ov && OutReady) begin
                m_ov = 1'b0;
            end
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
